// File: rtl/apb_dac_pkg.sv
// Shared definitions for the APB DAC writer: register map, SPI command nibble,
// register bit positions and the SPI sequencer state encoding.
package apb_dac_pkg;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  // Write-and-update command placed ahead of every code in the SPI frame.
  localparam logic [3:0] DAC_CMD = 4'b0011;

  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_CNT_LSB   = 4;
  localparam int STATUS_OVF_BIT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dac_state_t;

endpackage

// File: rtl/apb_dac_fifo.sv
// Synchronous code buffer between the APB write port and the SPI sequencer.
// Flush wins over push/pop; push when full and pop when empty are ignored.
module apb_dac_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_din,
  output logic [W-1:0]             o_dout,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge PCLK) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/apb_dac_writer.sv
// APB3 write-side peripheral: buffers PID output codes and serialises each one
// as a {DAC_CMD, code} SPI frame to an external DAC.
module apb_dac_writer
  import apb_dac_pkg::*;
#(
  parameter int DAC_W      = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4,
  parameter int FRAME_W    = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        DAC_SCLK,
  output logic        DAC_CS_N,
  output logic        DAC_SDI,
  output dac_state_t  o_dbg_state
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * FRAME_W);
  localparam int GAP_W  = $clog2(2 * CLK_DIV + 1);

  // APB: zero-wait slave. An access is PSEL&PENABLE; every side effect commits on
  // the PCLK edge that ends it, and PSLVERR is only ever raised during the access.
  logic             w_access, w_wr;
  logic             w_sel_data, w_sel_status, w_sel_ctrl, w_mapped;
  logic             w_push, w_pop, w_flush, w_ovf_evt;
  logic             w_full, w_empty;
  logic [CNT_W-1:0] w_count;
  logic [DAC_W-1:0] w_fifo_dout;
  logic [31:0]      w_status;
  logic             w_last_tick, w_gap_done;
  logic             w_unused;

  logic               r_en, r_ovf;
  dac_state_t         r_state, w_next;
  logic [FRAME_W-1:0] r_shreg;
  logic [DIV_W-1:0]   r_div;
  logic [EDGE_W-1:0]  r_edges;
  logic [GAP_W-1:0]   r_gap;
  logic               r_sclk, r_cs_n, r_sdi;

  assign w_access     = PSEL & PENABLE;
  assign w_wr         = w_access & PWRITE;
  assign w_sel_data   = (PADDR == ADDR_DATA);
  assign w_sel_status = (PADDR == ADDR_STATUS);
  assign w_sel_ctrl   = (PADDR == ADDR_CTRL);
  assign w_mapped     = w_sel_data | w_sel_status | w_sel_ctrl;
  assign w_push       = w_wr & w_sel_data & ~w_full;
  assign w_ovf_evt    = w_wr & w_sel_data & w_full;
  assign w_flush      = w_wr & w_sel_ctrl & PWDATA[CTRL_FLUSH_BIT];
  assign w_pop        = (r_state == ST_IDLE) & r_en & ~w_empty;
  assign w_unused     = ^PWDATA[31:DAC_W];

  assign PREADY      = 1'b1;
  assign PSLVERR     = (w_access & ~w_mapped) | w_ovf_evt;
  assign DAC_SCLK    = r_sclk;
  assign DAC_CS_N    = r_cs_n;
  assign DAC_SDI     = r_sdi;
  assign o_dbg_state = r_state;

  apb_dac_fifo #(.W(DAC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (PWDATA[DAC_W-1:0]),
    .o_dout  (w_fifo_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_status = '0;
    w_status[STATUS_FULL_BIT]            = w_full;
    w_status[STATUS_EMPTY_BIT]           = w_empty;
    w_status[STATUS_BUSY_BIT]            = (r_state != ST_IDLE);
    w_status[STATUS_CNT_LSB +: CNT_W]    = w_count;
    w_status[STATUS_OVF_BIT]             = r_ovf;
  end

  always_comb begin
    PRDATA = '0;
    case (PADDR)
      ADDR_STATUS: PRDATA = w_status;
      ADDR_CTRL:   PRDATA = {31'd0, r_en};
      default:     PRDATA = '0;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_en  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr & w_sel_ctrl) r_en <= PWDATA[CTRL_EN_BIT];
      if (w_ovf_evt) r_ovf <= 1'b1;
      else if (w_wr & w_sel_status & PWDATA[STATUS_OVF_BIT]) r_ovf <= 1'b0;
    end
  end

  // The 2*FRAME_W-th divider tick is the low half after the last rising edge.
  assign w_last_tick = ~r_cs_n & (r_div == DIV_W'(CLK_DIV - 1)) &
                       (r_edges == EDGE_W'(2 * FRAME_W - 1));
  assign w_gap_done  = (r_gap == GAP_W'(2 * CLK_DIV - 1));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_pop) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last_tick) w_next = ST_GAP;
      ST_GAP:   if (w_gap_done) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_shreg <= '0;
      r_div   <= '0;
      r_edges <= '0;
      r_gap   <= '0;
      r_sclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sdi   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_pop) r_shreg <= FRAME_W'({DAC_CMD, w_fifo_dout});
        ST_SHIFT: begin
          // CS_N still high marks the first SHIFT cycle: open the frame.
          if (r_cs_n) begin
            r_cs_n  <= 1'b0;
            r_sdi   <= r_shreg[FRAME_W-1];
            r_div   <= '0;
            r_edges <= '0;
          end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
            r_div <= '0;
            if (w_last_tick) begin
              r_cs_n <= 1'b1;
              r_sdi  <= 1'b0;
              r_sclk <= 1'b0;
              r_gap  <= '0;
            end else begin
              r_sclk  <= ~r_sclk;
              r_edges <= r_edges + EDGE_W'(1);
              if (r_sclk) begin
                r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
                r_sdi   <= r_shreg[FRAME_W-2];
              end
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end
        ST_GAP:  r_gap <= r_gap + GAP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_dac_writer.sv
// Directed bench for apb_dac_writer: APB driver tasks, an SPI frame monitor and
// an expected-frame queue filled at write time and drained at each frame end.
module tb_apb_dac_writer;
  import apb_dac_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [3:0]  PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, DAC_SCLK, DAC_CS_N, DAC_SDI;
  dac_state_t  dbg_state;

  apb_dac_writer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .DAC_SCLK(DAC_SCLK),
    .DAC_CS_N(DAC_CS_N), .DAC_SDI(DAC_SDI), .o_dbg_state(dbg_state)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  int          frames_done = 0;
  int          sclk_rises = 0;
  int          mon_bits = 0;
  int          mon_low = 0;
  logic [15:0] mon_shift = '0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        setup_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] addr, input logic [31:0] data, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge PCLK); setup_err = PSLVERR;
    @(posedge PCLK); #1; PENABLE = 1'b1;
    @(negedge PCLK); err = PSLVERR;
    @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] addr, output logic [31:0] data, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1; PENABLE = 1'b1;
    @(negedge PCLK); data = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1; PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic write_code(input logic [11:0] code);
    logic e;
    apb_write(ADDR_DATA, {20'd0, code}, e);
    check("data_wr_err", e, 1'b0);
    exp_q.push_back({DAC_CMD, code});
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(addr, d, e);
    check(tag, d, exp);
  endtask

  task automatic wait_frames(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && frames_done < target; i++) @(negedge PCLK);
    check(tag, frames_done, target);
  endtask

  task automatic wait_bits(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && mon_bits < target; i++) @(negedge PCLK);
    check(tag, mon_bits, target);
  endtask

  // SPI monitor: DAC samples SDI on SCLK rising edges while CS_N is low.
  always @(negedge PCLK) begin
    logic [15:0] exp_v;
    if (!PRESETn) begin
      mon_bits = 0; mon_low = 0; mon_shift = '0;
      prev_cs = 1'b1; prev_sclk = 1'b0;
    end else begin
      if (!prev_sclk && DAC_SCLK) begin
        sclk_rises++;
        if (!DAC_CS_N) begin
          mon_shift = {mon_shift[14:0], DAC_SDI};
          mon_bits++;
        end
      end
      if (!DAC_CS_N) mon_low++;
      if (!prev_cs && DAC_CS_N) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check("frame_data", mon_shift, exp_v);
        check("frame_bits", mon_bits, 16);
        check("frame_cs_low_cycles", mon_low, 128);
        frames_done++;
        mon_bits = 0; mon_low = 0; mon_shift = '0;
      end
      prev_cs = DAC_CS_N;
      prev_sclk = DAC_SCLK;
    end
  end

  initial begin
    logic        e;
    logic [31:0] d;
    int          base;

    // Reset state
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("reset_sclk", DAC_SCLK, 1'b0);
    check("reset_cs_n", DAC_CS_N, 1'b1);
    check("reset_sdi", DAC_SDI, 1'b0);
    check("pready", PREADY, 1'b1);
    read_check("reset_status", ADDR_STATUS, 32'h002);
    read_check("reset_ctrl", ADDR_CTRL, 32'h0);

    // Single frame, latency and busy
    apb_write(ADDR_CTRL, 32'h1, e);
    check("ctrl_wr_err", e, 1'b0);
    write_code(12'hABC);
    @(negedge PCLK); check("lat_cs_n_edge_n", DAC_CS_N, 1'b1);
    @(negedge PCLK); check("lat_cs_n_edge_n1", DAC_CS_N, 1'b1);
    @(negedge PCLK); check("lat_cs_n_edge_n2", DAC_CS_N, 1'b0);
    repeat (40) @(negedge PCLK);
    read_check("status_busy_mid_frame", ADDR_STATUS, 32'h006);
    wait_frames(1, 200, "frame1_done");

    // Overflow with en=0, then drain in order
    apb_write(ADDR_CTRL, 32'h0, e);
    repeat (10) @(negedge PCLK);
    for (int i = 1; i <= 4; i++) write_code(12'(i));
    apb_write(ADDR_DATA, 32'h005, e);
    check("ovf_pslverr", e, 1'b1);
    check("ovf_setup_pslverr", setup_err, 1'b0);
    read_check("status_ovf_full", ADDR_STATUS, 32'h141);
    apb_write(ADDR_CTRL, 32'h1, e);
    wait_frames(5, 700, "frames_1_to_4_done");
    repeat (12) @(negedge PCLK);
    read_check("status_ovf_sticky", ADDR_STATUS, 32'h102);
    apb_write(ADDR_STATUS, 32'h100, e);
    read_check("status_ovf_w1c", ADDR_STATUS, 32'h002);

    // Unmapped address and DATA readback
    apb_read(4'hC, d, e);
    check("unmapped_rd_err", e, 1'b1);
    check("unmapped_rd_data", d, 32'h0);
    apb_write(4'hC, 32'hFFFF_FFFF, e);
    check("unmapped_wr_err", e, 1'b1);
    read_check("ctrl_after_unmapped", ADDR_CTRL, 32'h1);
    read_check("status_after_unmapped", ADDR_STATUS, 32'h002);
    apb_read(ADDR_DATA, d, e);
    check("data_rd_zero", d, 32'h0);
    check("data_rd_err", e, 1'b0);

    // Disable mid-frame: frame completes, no further pop
    apb_write(ADDR_CTRL, 32'h0, e);
    write_code(12'h111);
    write_code(12'h222);
    read_check("status_count2", ADDR_STATUS, 32'h020);
    apb_write(ADDR_CTRL, 32'h1, e);
    wait_bits(2, 100, "reach_bit3");
    repeat (5) @(negedge PCLK);
    apb_write(ADDR_CTRL, 32'h0, e);
    wait_frames(6, 200, "frame_after_disable_done");
    repeat (100) @(negedge PCLK);
    check("no_pop_after_disable", frames_done, 6);
    read_check("status_count1_idle", ADDR_STATUS, 32'h010);

    // Flush together with enable
    write_code(12'h333);
    write_code(12'h444);
    read_check("status_count3", ADDR_STATUS, 32'h030);
    apb_write(ADDR_CTRL, 32'h3, e);
    exp_q.delete();
    read_check("ctrl_after_flush", ADDR_CTRL, 32'h1);
    read_check("status_after_flush", ADDR_STATUS, 32'h002);
    repeat (50) @(negedge PCLK);
    check("no_frame_after_flush", frames_done, 6);

    // Reset mid-frame aborts at once
    write_code(12'h555);
    write_code(12'h666);
    wait_bits(4, 100, "reach_mid_shift");
    check("state_shift_before_reset", dbg_state, ST_SHIFT);
    @(negedge PCLK); #2;
    PRESETn = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_cs_n", DAC_CS_N, 1'b1);
    check("async_reset_sclk", DAC_SCLK, 1'b0);
    check("async_reset_sdi", DAC_SDI, 1'b0);
    repeat (2) @(negedge PCLK);
    #1 PRESETn = 1'b1;
    base = sclk_rises;
    repeat (100) @(negedge PCLK);
    check("no_sclk_after_reset", sclk_rises, base);
    check("cs_idle_after_reset", DAC_CS_N, 1'b1);
    read_check("status_after_reset", ADDR_STATUS, 32'h002);
    read_check("ctrl_after_reset", ADDR_CTRL, 32'h0);

    check("total_frames", frames_done, 6);
    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
